udp_tx_scheduler: RTL and testbench

UDP_TX_SCHEDULER -- requirements
Module: udp_tx_scheduler

---
 rtl/udp_tx_scheduler.sv | 139 +++++++++++++
 tb/tb_udp_tx_scheduler.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_tx_scheduler.sv
// Round-robin UDP transmit scheduler: grants one channel at a time, strobes the sender, waits for end_tx or timeout.
// Grant two cycles after IDLE sees a request; no backpressure, requesters hold req until their one-cycle ack.
module udp_tx_scheduler #(
    parameter int N_CH    = 4,
    parameter int EN_LEN  = 3,
    parameter int GAP     = 12,
    parameter int TIMEOUT = 4096,
    parameter int MAX_LEN = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sched_en,
    input  logic [N_CH-1:0]      req,
    input  logic [16*N_CH-1:0]   req_len,
    input  logic [32*N_CH-1:0]   req_time,
    input  logic                 end_tx,
    output logic                 en,
    output logic [7:0]           channel,
    output logic [15:0]          mem_length,
    output logic [31:0]          time_buf,
    output logic [N_CH-1:0]      ack,
    output logic                 err,
    output logic                 busy,
    output logic [15:0]          pkt_cnt,
    output logic [7:0]           to_cnt
);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_WAIT, S_GAP} state_t;

    state_t         state, state_nxt;
    logic [31:0]    cnt;
    logic [2:0]     rr_ptr, win_idx, c;
    logic [7:0]     req_pad;
    logic           win_vld, len_bad;
    logic [15:0]    win_len;
    logic [31:0]    win_time;
    logic [N_CH-1:0] oh_win, oh_ch;

    assign req_pad = 8'(req);
    assign en      = (state == S_START);
    assign busy    = (state != S_IDLE);

    // Rotating search beginning one past the last winner.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        c = (rr_ptr == 3'(N_CH-1)) ? 3'd0 : rr_ptr + 3'd1;
        for (int i = 0; i < N_CH; i++) begin
            if (!win_vld && req_pad[c]) begin
                win_vld = 1'b1;
                win_idx = c;
            end
            c = (c == 3'(N_CH-1)) ? 3'd0 : c + 3'd1;
        end
    end

    always_comb begin
        win_len  = '0;
        win_time = '0;
        oh_win   = '0;
        oh_ch    = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (win_idx == 3'(i)) begin
                win_len   = req_len[16*i +: 16];
                win_time  = req_time[32*i +: 32];
                oh_win[i] = 1'b1;
            end
            if (channel[2:0] == 3'(i)) oh_ch[i] = 1'b1;
        end
    end

    assign len_bad = (win_len == 16'd0) || (win_len[1:0] != 2'b00) ||
                     (32'(win_len) > 32'(MAX_LEN));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (sched_en && (req != '0)) state_nxt = S_LOAD;
            S_LOAD:  begin
                if (!win_vld)     state_nxt = S_IDLE;
                else if (len_bad) state_nxt = S_GAP;
                else              state_nxt = S_START;
            end
            S_START: if (cnt == 32'(EN_LEN-1)) state_nxt = S_WAIT;
            S_WAIT:  if (end_tx || (cnt == 32'(TIMEOUT-1))) state_nxt = S_GAP;
            S_GAP:   if (cnt == 32'(GAP-1)) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // One counter serves START, WAIT and GAP; it restarts on every state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  cnt <= '0;
        else if (state_nxt != state) cnt <= '0;
        else                         cnt <= cnt + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr     <= 3'(N_CH-1);
            channel    <= '0;
            mem_length <= '0;
            time_buf   <= '0;
            ack        <= '0;
            err        <= 1'b0;
            pkt_cnt    <= '0;
            to_cnt     <= '0;
        end else begin
            ack <= '0;
            err <= 1'b0;
            if (state == S_LOAD && win_vld) begin
                rr_ptr     <= win_idx;
                channel    <= {5'b0, win_idx};
                mem_length <= win_len;
                time_buf   <= win_time;
                if (len_bad) begin
                    ack <= oh_win;
                    err <= 1'b1;
                end
            end
            if (state == S_WAIT) begin
                // Completion wins over a timeout landing in the same cycle.
                if (end_tx) begin
                    ack     <= oh_ch;
                    pkt_cnt <= pkt_cnt + 16'd1;
                end else if (cnt == 32'(TIMEOUT-1)) begin
                    err <= 1'b1;
                    if (to_cnt != 8'hFF) to_cnt <= to_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_udp_tx_scheduler.sv
// Scoreboard bench for udp_tx_scheduler: driver predicts each ack/err event from a behavioural model,
// an independent monitor pops and compares whenever the DUT pulses ack or err.
module tb_udp_tx_scheduler;

    localparam int N_CH    = 4;
    localparam int EN_LEN  = 3;
    localparam int GAP     = 12;
    localparam int TIMEOUT = 4096;
    localparam int MAX_LEN = 1024;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sched_en = 1'b0;
    logic [3:0]    req = '0;
    logic [63:0]   req_len = '0;
    logic [127:0]  req_time = '0;
    logic          end_tx = 1'b0;
    logic          en;
    logic [7:0]    channel;
    logic [15:0]   mem_length;
    logic [31:0]   time_buf;
    logic [3:0]    ack;
    logic          err;
    logic          busy;
    logic [15:0]   pkt_cnt;
    logic [7:0]    to_cnt;

    udp_tx_scheduler #(
        .N_CH(N_CH), .EN_LEN(EN_LEN), .GAP(GAP), .TIMEOUT(TIMEOUT), .MAX_LEN(MAX_LEN)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sched_en(sched_en), .req(req), .req_len(req_len),
        .req_time(req_time), .end_tx(end_tx), .en(en), .channel(channel),
        .mem_length(mem_length), .time_buf(time_buf), .ack(ack), .err(err),
        .busy(busy), .pkt_cnt(pkt_cnt), .to_cnt(to_cnt)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [3:0]  ack;
        logic        err;
        logic [7:0]  ch;
        logic [15:0] len;
        logic [31:0] tm;
        logic [15:0] pkt;
        logic [7:0]  to;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   ev_cnt = 0;
    int   last_ev_cyc = 0;
    int   m_ptr = N_CH - 1;
    int   m_pkt = 0;
    int   m_to = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic bail(input string name);
        checks++;
        errors++;
        $display("FAIL %s wait bound expired (cycle %0d)", name, cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    // Reference model: rotate from one past the previous winner, first requester wins.
    function automatic int rr_winner(input logic [3:0] r, input int ptr);
        for (int k = 1; k <= N_CH; k++) begin
            int idx = (ptr + k) % N_CH;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic bit len_ok(input logic [15:0] l);
        return (l != 0) && (l % 4 == 0) && (int'(l) <= MAX_LEN);
    endfunction

    function automatic logic [15:0] rand_len();
        case ($urandom_range(0, 9))
            0:       return 16'd0;
            1:       return 16'(4 * $urandom_range(1, 255) + $urandom_range(1, 3));
            2:       return 16'(MAX_LEN + 4 * $urandom_range(1, 100));
            3:       return 16'(MAX_LEN);
            4:       return 16'd4;
            default: return 16'(4 * $urandom_range(1, 256));
        endcase
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic check_reset_vals();
        chk("rst_en", 32'(en), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_channel", 32'(channel), 32'd0);
        chk("rst_mem_length", 32'(mem_length), 32'd0);
        chk("rst_time_buf", time_buf, 32'd0);
        chk("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
        chk("rst_to_cnt", 32'(to_cnt), 32'd0);
    endtask

    // Monitor: every ack/err pulse must match the oldest prediction.
    initial forever begin
        @(negedge clk);
        if (rst_n && (ack != '0 || err)) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event ack=%b err=%b (cycle %0d)", ack, err, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("mon_ack", 32'(ack), 32'(e.ack));
                chk("mon_err", 32'(err), 32'(e.err));
                chk("mon_channel", 32'(channel), 32'(e.ch));
                chk("mon_mem_length", 32'(mem_length), 32'(e.len));
                chk("mon_time_buf", time_buf, e.tm);
                chk("mon_pkt_cnt", 32'(pkt_cnt), 32'(e.pkt));
                chk("mon_to_cnt", 32'(to_cnt), 32'(e.to));
            end
            last_ev_cyc = cyc;
            ev_cnt++;
        end
    end

    // mode: 0 random end_tx delay, 1 delay 50, 2 no end_tx (timeout), 3 end_tx on final timeout cycle
    task automatic do_packet(input int mode, input bit chk_gap, input bit stray, input bit sen_drop);
        int   w, ev0, prev_ev, budget, width, wait0, d;
        bit   ok;
        exp_t e;
        w = rr_winner(req, m_ptr);
        if (w < 0) bail("no_requester");
        m_ptr = w;
        e.ch  = 8'(w);
        e.len = req_len[16*w +: 16];
        e.tm  = req_time[32*w +: 32];
        ok = len_ok(e.len);
        if (!ok) begin
            e.ack = 4'(1 << w);
            e.err = 1'b1;
        end else if (mode == 2) begin
            e.ack = 4'b0;
            e.err = 1'b1;
            if (m_to < 255) m_to++;
        end else begin
            e.ack = 4'(1 << w);
            e.err = 1'b0;
            m_pkt = (m_pkt + 1) % 65536;
        end
        e.pkt = 16'(m_pkt);
        e.to  = 8'(m_to);
        q.push_back(e);
        ev0 = ev_cnt;
        prev_ev = last_ev_cyc;

        budget = 200;
        forever begin
            step();
            if (en || ev_cnt != ev0) break;
            budget--;
            if (budget == 0) bail("grant_wait");
        end
        if (chk_gap) chk("grant_spacing", 32'(cyc - prev_ev), 32'(GAP + 2));
        chk("en_on_grant", 32'(en), 32'(ok));

        if (ok && en) begin
            width = 1;
            if (sen_drop) sched_en = 1'b0;
            if (stray) end_tx = 1'b1;
            forever begin
                step();
                end_tx = 1'b0;
                if (!en) break;
                width++;
                if (width > 100) bail("en_fall_wait");
            end
            chk("en_width", 32'(width), 32'(EN_LEN));
            wait0 = cyc;
            d = (mode == 0) ? int'($urandom_range(1, 60)) : (mode == 1) ? 50 : TIMEOUT - 1;
            if (mode != 2) begin
                repeat (d) step();
                end_tx = 1'b1;
                step();
                end_tx = 1'b0;
            end
            budget = TIMEOUT + 200;
            while (ev_cnt == ev0) begin
                step();
                budget--;
                if (budget == 0) bail("event_wait");
            end
            chk("done_latency", 32'(last_ev_cyc - wait0), 32'(d + 1));
        end
        sched_en = 1'b1;
        if (e.ack != 0) req[w] = 1'b0;
    endtask

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog expired (cycle %0d)", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        repeat (3) step();
        check_reset_vals();
        rst_n = 1'b1;

        // Requests present but scheduler disabled: nothing may start.
        req = 4'b1111;
        for (int i = 0; i < N_CH; i++) begin
            req_len[16*i +: 16]  = 16'(64 + 4 * i);
            req_time[32*i +: 32] = 32'hA000_0000 + 32'(i);
        end
        repeat (20) begin
            step();
            chk("disabled_busy", 32'(busy), 32'd0);
        end

        // Fairness: all channels held, expected order 0,1,2,3,0.
        sched_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            do_packet(0, i > 0, 1'b0, 1'b0);
            req = 4'b1111;
        end

        // Single request with known values.
        req = 4'b0001;
        req_len[15:0]  = 16'd32;
        req_time[31:0] = 32'h1234_5678;
        do_packet(1, 1'b1, 1'b0, 1'b0);

        // Misaligned length dropped on channel 2.
        req = 4'b0100;
        req_len[47:32] = 16'd30;
        do_packet(0, 1'b1, 1'b0, 1'b0);

        // Timeout on channel 1, then the same channel served again.
        req = 4'b0010;
        req_len[31:16] = 16'd64;
        do_packet(2, 1'b1, 1'b0, 1'b0);
        do_packet(0, 1'b1, 1'b0, 1'b0);

        // end_tx coinciding with the last timeout cycle counts as completion.
        req = 4'b1000;
        req_len[63:48] = 16'(MAX_LEN);
        do_packet(3, 1'b1, 1'b0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < N_CH; i++) begin
                req_len[16*i +: 16]  = rand_len();
                req_time[32*i +: 32] = $urandom();
            end
            req = req | 4'($urandom_range(0, 15));
            if (req == 4'b0) req = 4'(1 << $urandom_range(0, 3));
            do_packet(0, 1'b1, ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0));
        end

        // Reset while waiting for end_tx on channel 2.
        req = 4'b0100;
        req_len[47:32]  = 16'd128;
        req_time[95:64] = 32'hCAFE_0002;
        begin
            int budget;
            budget = 200;
            while (!en) begin
                step();
                budget--;
                if (budget == 0) bail("reset_test_en_wait");
            end
            budget = 20;
            while (en) begin
                step();
                budget--;
                if (budget == 0) bail("reset_test_en_fall");
            end
        end
        repeat (10) step();
        rst_n = 1'b0;
        #1;
        check_reset_vals();
        q.delete();
        m_ptr = N_CH - 1;
        m_pkt = 0;
        m_to  = 0;
        repeat (3) step();
        check_reset_vals();
        rst_n = 1'b1;
        do_packet(0, 1'b0, 1'b0, 1'b0);

        repeat (GAP + 5) step();
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
